// File: rtl/keep_one_in_n_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keep_one_in_n_mc_pkg
// Purpose  : Shared mode encoding and helper functions for the multi-channel
//            keep-one-in-n / integrate-and-dump decimator.
// Revision : 1.0  initial release
// ============================================================================
package keep_one_in_n_mc_pkg;

    // Operating mode of the decimator
    typedef enum logic {
        MODE_KEEP = 1'b0,
        MODE_AVG  = 1'b1
    } mode_e;

    // Accumulator width needed to sum MAX_N samples of WIDTH bits without overflow
    function automatic int acc_width(input int width, input int max_n);
        return width + $clog2(max_n + 1);
    endfunction

    // Clamp a signed value into the signed range of a WIDTH-bit lane
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                      input int              width);
        logic signed [63:0] v_hi;
        logic signed [63:0] v_lo;
        v_hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        v_lo = -(64'sd1 <<< (width - 1));
        if (value > v_hi) begin
            return v_hi;
        end else if (value < v_lo) begin
            return v_lo;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keep_one_in_n_mc_lane_acc.sv
`default_nettype none
// ============================================================================
// Module   : keep_one_in_n_mc_lane_acc
// Purpose  : One lane of the integrate-and-dump path: signed accumulator,
//            arithmetic right shift and reduction to WIDTH bits.
//            Build option KEEP_ONE_IN_N_MC_SAT_EN selects saturation instead
//            of wrap-around when reducing the shifted sum.
// Revision : 1.0  initial release
// ============================================================================
module keep_one_in_n_mc_lane_acc
    import keep_one_in_n_mc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_N     = 65535,
    parameter int MAX_SHIFT = 31,
    parameter int SHIFT_W   = $clog2(MAX_SHIFT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   x_i,        // lane sample
    input  logic               first_i,    // sample opens a new window
    input  logic               accept_i,   // beat accepted this cycle
    input  logic               last_i,     // sample closes the window
    input  logic               restart_i,  // window restart from config change
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [WIDTH-1:0]   result_o    // value loaded on a last beat
);

    localparam int ACC_W = acc_width(WIDTH, MAX_N);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] w_sext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_shifted;
    logic [SHIFT_W-1:0]      w_shamt;

    assign w_sext     = {{(ACC_W - WIDTH){x_i[WIDTH-1]}}, x_i};
    // A first sample overwrites whatever the previous window left behind,
    // so no dedicated clear cycle is needed between windows.
    assign w_acc_next = first_i ? w_sext : (acc_q + w_sext);
    assign w_shamt    = (shift_i > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift_i;
    assign w_shifted  = w_acc_next >>> w_shamt;

`ifdef KEEP_ONE_IN_N_MC_SAT_EN
    logic signed [63:0] w_sat;
    assign w_sat    = sat_trunc({{(64 - ACC_W){w_shifted[ACC_W-1]}}, w_shifted}, WIDTH);
    assign result_o = w_sat[WIDTH-1:0];
`else
    assign result_o = w_shifted[WIDTH-1:0];
`endif

    // Next accumulator: keep partial sums, clear on a restart without a beat
    always_comb begin
        acc_d = acc_q;
        if (accept_i && !last_i) begin
            acc_d = w_acc_next;
        end else if (restart_i) begin
            acc_d = '0;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keep_one_in_n_mc.sv
`default_nettype none
// ============================================================================
// Module   : keep_one_in_n_mc
// Purpose  : Multi-channel AXI-Stream decimator. Keeps one beat in n (keep
//            mode) or integrates-and-dumps n beats per lane followed by an
//            arithmetic right shift (average mode). One packet boundary in n
//            is passed on o_tlast.
//            Build option KEEP_ONE_IN_N_MC_SAT_EN: saturate averaged lanes.
// Revision : 1.0  initial release
// ============================================================================
module keep_one_in_n_mc
    import keep_one_in_n_mc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_CH    = 2,
    parameter int MAX_N     = 65535,
    parameter int MAX_SHIFT = 31
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$clog2(MAX_N+1)-1:0]       n,
    input  logic                             mode,
    input  logic [$clog2(MAX_SHIFT+1)-1:0]   shift,
    input  logic [NUM_CH*WIDTH-1:0]          i_tdata,
    input  logic                             i_tlast,
    input  logic                             i_tvalid,
    output logic                             i_tready,
    output logic [NUM_CH*WIDTH-1:0]          o_tdata,
    output logic                             o_tlast,
    output logic                             o_tvalid,
    input  logic                             o_tready
);

    localparam int N_W = $clog2(MAX_N + 1);
    localparam int S_W = $clog2(MAX_SHIFT + 1);

    logic [N_W-1:0]          n_q;
    mode_e                   mode_q;
    logic [S_W-1:0]          shift_q;
    logic                    restart_q;

    logic [N_W-1:0]          sample_cnt_q;
    logic [N_W-1:0]          sample_cnt_d;
    logic [N_W-1:0]          pkt_cnt_q;
    logic [N_W-1:0]          pkt_cnt_d;

    logic                    out_valid_q;
    logic                    out_valid_d;
    logic                    out_last_q;
    logic                    out_last_d;
    logic [NUM_CH*WIDTH-1:0] out_data_q;
    logic [NUM_CH*WIDTH-1:0] out_data_d;

    logic [N_W-1:0]          w_sample_cnt;
    logic [N_W-1:0]          w_pkt_cnt;
    logic                    w_on_last_sample;
    logic                    w_on_last_pkt;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_first;
    logic [NUM_CH*WIDTH-1:0] w_avg_data;

    // A restart cycle behaves as if both counters already sit at 1, so a
    // beat accepted in that cycle opens the new window.
    assign w_sample_cnt     = restart_q ? N_W'(1) : sample_cnt_q;
    assign w_pkt_cnt        = restart_q ? N_W'(1) : pkt_cnt_q;
    assign w_on_last_sample = (w_sample_cnt >= n_q);
    assign w_on_last_pkt    = (w_pkt_cnt >= n_q);
    assign w_first          = (w_sample_cnt == N_W'(1));

    // Only a last beat needs the output register, so only it can be stalled
    assign w_ready  = !w_on_last_sample || !out_valid_q || o_tready;
    assign w_accept = i_tvalid && w_ready;
    assign w_load   = w_accept && w_on_last_sample;

    assign i_tready = w_ready;
    assign o_tvalid = out_valid_q;
    assign o_tlast  = out_last_q;
    assign o_tdata  = out_data_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        keep_one_in_n_mc_lane_acc #(
            .WIDTH     (WIDTH),
            .MAX_N     (MAX_N),
            .MAX_SHIFT (MAX_SHIFT),
            .SHIFT_W   (S_W)
        ) u_lane_acc (
            .clk       (clk),
            .reset     (reset),
            .x_i       (i_tdata[k*WIDTH +: WIDTH]),
            .first_i   (w_first),
            .accept_i  (w_accept),
            .last_i    (w_on_last_sample),
            .restart_i (restart_q),
            .shift_i   (shift_q),
            .result_o  (w_avg_data[k*WIDTH +: WIDTH])
        );
    end

    // Config capture; a change of n or mode flags a one-cycle restart
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q       <= N_W'(1);
            mode_q    <= MODE_KEEP;
            shift_q   <= '0;
            restart_q <= 1'b0;
        end else begin
            n_q       <= n;
            mode_q    <= mode_e'(mode);
            shift_q   <= shift;
            restart_q <= (n != n_q) || (mode != mode_q);
        end
    end

    // Next sample and packet counters
    always_comb begin
        sample_cnt_d = w_sample_cnt;
        pkt_cnt_d    = w_pkt_cnt;
        if (w_accept) begin
            sample_cnt_d = w_on_last_sample ? N_W'(1) : (w_sample_cnt + N_W'(1));
            if (i_tlast) begin
                pkt_cnt_d = w_on_last_pkt ? N_W'(1) : (w_pkt_cnt + N_W'(1));
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt_q <= N_W'(1);
            pkt_cnt_q    <= N_W'(1);
        end else begin
            sample_cnt_q <= sample_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    // Output stage next state: load on a last beat, else drain on handshake
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (w_load) begin
            out_valid_d = 1'b1;
            out_last_d  = i_tlast && w_on_last_pkt;
            out_data_d  = (mode_q == MODE_AVG) ? w_avg_data : i_tdata;
        end else if (o_tready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keep_one_in_n_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_keep_one_in_n_mc
// Purpose  : Self-checking bench for keep_one_in_n_mc against a window-sum
//            reference model and an output scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_keep_one_in_n_mc;

    localparam int WIDTH     = 16;
    localparam int NUM_CH    = 2;
    localparam int MAX_N     = 65535;
    localparam int MAX_SHIFT = 31;
    localparam int N_W       = $clog2(MAX_N + 1);
    localparam int S_W       = $clog2(MAX_SHIFT + 1);
    localparam int D_W       = NUM_CH * WIDTH;

    logic           clk = 1'b0;
    logic           reset;
    logic [N_W-1:0] n;
    logic           mode;
    logic [S_W-1:0] shift;
    logic [D_W-1:0] i_tdata;
    logic           i_tlast;
    logic           i_tvalid;
    logic           i_tready;
    logic [D_W-1:0] o_tdata;
    logic           o_tlast;
    logic           o_tvalid;
    logic           o_tready;

    keep_one_in_n_mc #(
        .WIDTH     (WIDTH),
        .NUM_CH    (NUM_CH),
        .MAX_N     (MAX_N),
        .MAX_SHIFT (MAX_SHIFT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .n        (n),
        .mode     (mode),
        .shift    (shift),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [D_W-1:0] data;
        logic           last;
    } beat_t;

    int     checks = 0;
    int     errors = 0;
    beat_t  stim_q[$];
    beat_t  exp_q[$];

    // Reference model: window of samples summed per lane, packets counted
    int     m_n;
    int     m_mode;
    int     m_shift;
    int     m_sc;
    int     m_pc;
    longint m_sum [NUM_CH];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int n_eff();
        return (m_n == 0) ? 1 : m_n;
    endfunction

    function automatic void model_restart();
        m_sc = 0;
        m_pc = 0;
        for (int k = 0; k < NUM_CH; k++) m_sum[k] = 0;
    endfunction

    function automatic logic [WIDTH-1:0] model_reduce(input longint sum);
        longint r;
        longint hi;
        longint lo;
        int     sh;
        sh = (m_shift > MAX_SHIFT) ? MAX_SHIFT : m_shift;
        r  = sum >>> sh;
        hi = (longint'(1) <<< (WIDTH - 1)) - 1;
        lo = -hi - 1;
`ifdef KEEP_ONE_IN_N_MC_SAT_EN
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`endif
        return r[WIDTH-1:0];
    endfunction

    // Feed one accepted beat; returns 1 when it completes a window
    function automatic bit model_feed(input beat_t b);
        beat_t o;
        bit    lastpkt;
        lastpkt = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            logic signed [WIDTH-1:0] x;
            x = b.data[k*WIDTH +: WIDTH];
            m_sum[k] += longint'(x);
        end
        m_sc++;
        if (b.last) begin
            m_pc++;
            if (m_pc >= n_eff()) begin
                lastpkt = 1'b1;
                m_pc    = 0;
            end
        end
        if (m_sc >= n_eff()) begin
            if (m_mode == 0) begin
                o.data = b.data;
            end else begin
                for (int k = 0; k < NUM_CH; k++) o.data[k*WIDTH +: WIDTH] = model_reduce(m_sum[k]);
            end
            o.last = b.last && lastpkt;
            exp_q.push_back(o);
            m_sc = 0;
            for (int k = 0; k < NUM_CH; k++) m_sum[k] = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit next_is_last();
        return (m_sc + 1) >= n_eff();
    endfunction

    task automatic push_beat(input int l0, input int l1, input bit last);
        beat_t b;
        b.data[0 +: WIDTH]     = l0[WIDTH-1:0];
        b.data[WIDTH +: WIDTH] = l1[WIDTH-1:0];
        b.last = last;
        stim_q.push_back(b);
    endtask

    // Change config with the stream idle and the output held
    task automatic cfg(input int nn, input int md, input int sh);
        bit changed;
        changed  = (nn != m_n) || (md != m_mode);
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        n        = N_W'(nn);
        mode     = md[0];
        shift    = S_W'(sh);
        m_n      = nn;
        m_mode   = md;
        m_shift  = sh;
        repeat (3) @(posedge clk);
        #1;
        if (changed) model_restart();
    endtask

    // Drive the stimulus queue and score every output handshake
    task automatic stream(input int vprob, input int rprob, input int low_cycles);
        int    cyc;
        bit    hold;
        bit    prod;
        beat_t e;
        cyc  = 0;
        hold = 1'b0;
        prod = 1'b0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
            if (stim_q.size() > 0 && (hold || $urandom_range(99) < vprob)) begin
                i_tvalid = 1'b1;
                i_tdata  = stim_q[0].data;
                i_tlast  = stim_q[0].last;
            end else begin
                i_tvalid = 1'b0;
                i_tdata  = D_W'($urandom);
                i_tlast  = 1'($urandom_range(1));
            end
            o_tready = (cyc < low_cycles) ? 1'b0 : ($urandom_range(99) < rprob);
            @(negedge clk);
            if (prod) check_value("latency_valid", o_tvalid, 1);
            prod = 1'b0;
            check_value("i_tready", i_tready, !(next_is_last() && o_tvalid && !o_tready));
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    check_value("spurious_out", o_tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_value("o_tdata", o_tdata, e.data);
                    check_value("o_tlast", o_tlast, e.last);
                end
            end
            hold = i_tvalid && !i_tready;
            if (i_tvalid && i_tready) prod = model_feed(stim_q.pop_front());
            @(posedge clk);
            #1;
            cyc++;
        end
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        check_value("drained", 64'(stim_q.size() + exp_q.size()), 0);
    endtask

    initial begin
        reset    = 1'b1;
        n        = N_W'(1);
        mode     = 1'b0;
        shift    = '0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        m_n      = 1;
        m_mode   = 0;
        m_shift  = 0;
        model_restart();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_value("rst_o_tvalid", o_tvalid, 0);
        check_value("rst_o_tlast", o_tlast, 0);
        check_value("rst_o_tdata", o_tdata, 0);
        check_value("rst_i_tready", i_tready, 1);
        @(posedge clk);
        #1;

        // Keep mode, n = 4, ramp on both lanes
        cfg(4, 0, 0);
        for (int i = 0; i < 16; i++) push_beat(i, i, 1'b0);
        stream(100, 100, 0);

        // Average mode, n = 4, shift = 2
        cfg(4, 1, 2);
        push_beat(4, -4, 1'b0);
        push_beat(8, -4, 1'b0);
        push_beat(12, -4, 1'b0);
        push_beat(16, -4, 1'b0);
        stream(100, 100, 0);

        // Packet decimation: n = 3, 9 packets of 6 beats
        cfg(3, 0, 0);
        for (int i = 0; i < 54; i++) push_beat(i, 1000 + i, (i % 6) == 5);
        stream(100, 100, 0);

        // Backpressure: n = 2, sink stalled 5 cycles, then random
        cfg(2, 0, 0);
        for (int i = 0; i < 20; i++) push_beat(int'($urandom), int'($urandom), $urandom_range(3) == 0);
        stream(100, 100, 5);
        for (int i = 0; i < 30; i++) push_beat(int'($urandom), int'($urandom), $urandom_range(3) == 0);
        stream(80, 50, 0);

        // Saturation / wrap in average mode
        cfg(2, 1, 0);
        push_beat(30000, -30000, 1'b0);
        push_beat(30000, -30000, 1'b0);
        stream(100, 100, 0);

        // Config change mid-window: 3 beats at n = 4, then n = 2
        cfg(4, 0, 0);
        for (int i = 0; i < 3; i++) push_beat(50 + i, 60 + i, 1'b0);
        stream(100, 100, 0);
        cfg(2, 0, 0);
        push_beat(70, 80, 1'b0);
        push_beat(71, 81, 1'b0);
        stream(100, 100, 0);

        // Reset with a held output beat
        o_tready = 1'b0;
        i_tvalid = 1'b1;
        i_tlast  = 1'b0;
        i_tdata  = {16'd5, 16'd6};
        @(posedge clk);
        #1;
        i_tdata  = {16'd7, 16'd8};
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        @(negedge clk);
        check_value("held_valid", o_tvalid, 1);
        check_value("held_data", o_tdata, {16'd7, 16'd8});
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_value("mid_rst_o_tvalid", o_tvalid, 0);
        check_value("mid_rst_o_tlast", o_tlast, 0);
        check_value("mid_rst_o_tdata", o_tdata, 0);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        model_restart();
        push_beat(90, 91, 1'b1);
        push_beat(92, 93, 1'b1);
        push_beat(94, 95, 1'b0);
        push_beat(96, 97, 1'b1);
        stream(100, 100, 0);

        // Randomized configurations and traffic
        for (int r = 0; r < 8; r++) begin
            cfg(int'($urandom_range(0, 5)), int'($urandom_range(1)), int'($urandom_range(0, 3)));
            for (int i = 0; i < 30; i++) push_beat(int'($urandom), int'($urandom), $urandom_range(3) == 0);
            stream(70, 60, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
